// File: rtl/dshot_receiver_pkg.sv
// Shared DShot definitions. The transmit-side encoder uses the same field
// widths and CRC, so both sides stay consistent.
//   CmdW/TeleW/CrcW : packet field widths (11/1/4)
//   FrameLen        : bits per frame (16)
//   St*             : receiver state encodings
//   dshot_crc()     : 4-bit DShot checksum over the 12-bit value field
package dshot_receiver_pkg;

  localparam int unsigned CmdW     = 11;
  localparam int unsigned TeleW    = 1;
  localparam int unsigned CrcW     = 4;
  localparam int unsigned ValueW   = CmdW + TeleW;
  localparam int unsigned FrameLen = ValueW + CrcW;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StHigh  = 2'd1;
  localparam state_t StLow   = 2'd2;
  localparam state_t StCheck = 2'd3;

  function automatic logic [CrcW-1:0] dshot_crc(input logic [ValueW-1:0] value);
    logic [ValueW-1:0] folded;
    folded = value ^ (value >> 4) ^ (value >> 8);
    return folded[CrcW-1:0];
  endfunction

endpackage

// File: rtl/dshot_packet_decoder.sv
// Combinational split of a 16-bit DShot frame into command, telemetry request
// and an accept flag.
//   frame_i     : received frame, MSB first as shifted in
//   command_o   : value[11:1]
//   telemetry_o : value[0]
//   accept_o    : frame may be taken
// Build option: DSHOT_RX_CRC_CHECK_EN makes accept_o depend on the CRC match;
// without it every complete frame is accepted.
module dshot_packet_decoder
  import dshot_receiver_pkg::*;
(
  input  logic [FrameLen-1:0] frame_i,
  output logic [CmdW-1:0]     command_o,
  output logic                telemetry_o,
  output logic                accept_o
);

  logic [ValueW-1:0] value;

  assign value       = frame_i[FrameLen-1:CrcW];
  assign command_o   = value[ValueW-1:1];
  assign telemetry_o = value[0];

`ifdef DSHOT_RX_CRC_CHECK_EN
  assign accept_o = (dshot_crc(value) == frame_i[CrcW-1:0]);
`else
  logic unused_crc;
  assign unused_crc = ^frame_i[CrcW-1:0];
  assign accept_o   = 1'b1;
`endif

endmodule

// File: rtl/dshot_receiver.sv
// DShot frame receiver: synchronises the line, measures high/low widths,
// assembles 16 bits and hands them to dshot_packet_decoder.
//   clock        : sole clock, rising edge
//   resetN       : synchronous active-low reset
//   rxIn         : asynchronous DShot line
//   command      : command of last accepted frame
//   telemetryReq : telemetry bit of last accepted frame
//   valid        : one-cycle pulse when command/telemetryReq update
//   frameError   : one-cycle pulse on a rejected frame
// Build option: DSHOT_RX_CRC_CHECK_EN (see dshot_packet_decoder).
module dshot_receiver
  import dshot_receiver_pkg::*;
#(
  parameter int unsigned BASE_FREQ  = 16000000,
  parameter int unsigned DSHOT_FREQ = 600000
) (
  input  logic            clock,
  input  logic            resetN,
  input  logic            rxIn,
  output logic [CmdW-1:0] command,
  output logic            telemetryReq,
  output logic            valid,
  output logic            frameError
);

  localparam int unsigned ClksPerBit = BASE_FREQ / DSHOT_FREQ;
  localparam int unsigned CntW       = $clog2(2 * ClksPerBit + 1);
  localparam int unsigned IdxW       = $clog2(FrameLen);

  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] CntMax     = '1;
  localparam logic [CntW-1:0] HalfBit    = CntW'(ClksPerBit / 2);
  localparam logic [CntW-1:0] GlitchMin  = CntW'(ClksPerBit / 8);
  localparam logic [CntW-1:0] StuckHigh  = CntW'(ClksPerBit);
  localparam logic [CntW-1:0] LowTimeout = CntW'(2 * ClksPerBit);
  localparam logic [IdxW-1:0] LastBit    = IdxW'(FrameLen - 1);

  logic                sync1_q, sync2_q, line_prev_q;
  state_t              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
  logic [FrameLen-1:0] shift_q, shift_d;
  logic                stuck_q, stuck_d;
  logic [CmdW-1:0]     command_q, command_d;
  logic                tele_q, tele_d;
  logic                valid_q, valid_d;
  logic                frame_error_q, frame_error_d;

  logic [CmdW-1:0]     dec_command;
  logic                dec_tele, dec_accept;

  dshot_packet_decoder u_decoder (
    .frame_i     (shift_q),
    .command_o   (dec_command),
    .telemetry_o (dec_tele),
    .accept_o    (dec_accept)
  );

  // Saturating increment so long stuck/idle periods never wrap into a valid width.
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    stuck_d       = stuck_q;
    command_d     = command_q;
    tele_d        = tele_q;
    valid_d       = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (sync2_q && !line_prev_q) begin
          cnt_d     = CntOne;
          bit_idx_d = '0;
          stuck_d   = 1'b0;
          state_d   = StHigh;
        end
      end
      StHigh: begin
        if (!sync2_q) begin
          if (stuck_q) begin
            // Error already reported while high; just drop the frame.
            state_d = StIdle;
          end else if (cnt_q < GlitchMin) begin
            frame_error_d = 1'b1;
            state_d       = StIdle;
          end else begin
            shift_d   = {shift_q[FrameLen-2:0], (cnt_q >= HalfBit)};
            bit_idx_d = bit_idx_q + 1'b1;
            cnt_d     = CntOne;
            state_d   = (bit_idx_q == LastBit) ? StCheck : StLow;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q >= StuckHigh && !stuck_q) begin
            frame_error_d = 1'b1;
            stuck_d       = 1'b1;
          end
        end
      end
      StLow: begin
        if (sync2_q) begin
          cnt_d   = CntOne;
          state_d = StHigh;
        end else if (cnt_q >= LowTimeout) begin
          frame_error_d = 1'b1;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StCheck: begin
        if (dec_accept) begin
          command_d = dec_command;
          tele_d    = dec_tele;
          valid_d   = 1'b1;
        end else begin
          frame_error_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      line_prev_q   <= 1'b0;
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      stuck_q       <= 1'b0;
      command_q     <= '0;
      tele_q        <= 1'b0;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      sync1_q       <= rxIn;
      sync2_q       <= sync1_q;
      line_prev_q   <= sync2_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      stuck_q       <= stuck_d;
      command_q     <= command_d;
      tele_q        <= tele_d;
      valid_q       <= valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign command      = command_q;
  assign telemetryReq = tele_q;
  assign valid        = valid_q;
  assign frameError   = frame_error_q;

endmodule

// File: tb/tb_dshot_receiver.sv
module tb_dshot_receiver;

  logic        clock = 1'b0;
  logic        resetN;
  logic        rxIn;
  logic [10:0] command;
  logic        telemetryReq;
  logic        valid;
  logic        frameError;

  dshot_receiver dut (
    .clock        (clock),
    .resetN       (resetN),
    .rxIn         (rxIn),
    .command      (command),
    .telemetryReq (telemetryReq),
    .valid        (valid),
    .frameError   (frameError)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        err;
    logic [10:0] cmd;
    logic        tele;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [10:0] model_cmd  = '0;
  logic        model_tele = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every valid/frameError pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (valid || frameError) begin
      check("exclusive", {31'd0, valid && frameError}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, valid, frameError}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_kind", {31'd0, frameError}, {31'd0, e.err});
        if (!e.err) begin
          check("command", {21'd0, command}, {21'd0, e.cmd});
          check("telemetry", {31'd0, telemetryReq}, {31'd0, e.tele});
        end
      end
    end
  end

  task automatic expect_frame(input logic [15:0] f);
    logic [11:0] v;
    logic [11:0] c;
    logic        ok;
    exp_t        e;
    v = f[15:4];
    c = v ^ (v >> 4) ^ (v >> 8);
`ifdef DSHOT_RX_CRC_CHECK_EN
    ok = (c[3:0] == f[3:0]);
`else
    ok = 1'b1;
`endif
    e.err  = !ok;
    e.cmd  = v[11:1];
    e.tele = v[0];
    exp_q.push_back(e);
    if (ok) begin
      model_cmd  = v[11:1];
      model_tele = v[0];
    end
  endtask

  task automatic expect_error();
    exp_t e;
    e.err  = 1'b1;
    e.cmd  = '0;
    e.tele = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    rxIn = 1'b1;
    repeat (b ? 20 : 10) @(negedge clock);
    rxIn = 1'b0;
    repeat (b ? 6 : 16) @(negedge clock);
  endtask

  task automatic send_bits(input logic [15:0] f, input int n);
    for (int i = 15; i > 15 - n; i--) send_bit(f[i]);
  endtask

  task automatic settle(input string tag);
    repeat (80) @(negedge clock);
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_cmd_hold"}, {21'd0, command}, {21'd0, model_cmd});
    check({tag, "_tele_hold"}, {31'd0, telemetryReq}, {31'd0, model_tele});
  endtask

  initial begin
    resetN = 1'b0;
    rxIn   = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_command", {21'd0, command}, 32'd0);
    check("rst_tele", {31'd0, telemetryReq}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, frameError}, 32'd0);
    resetN = 1'b1;
    repeat (5) @(negedge clock);

    expect_frame(16'h8008);
    send_bits(16'h8008, 16);
    settle("f8008");

    expect_frame(16'h0617);
    expect_frame(16'h8008);
    send_bits(16'h0617, 16);
    send_bits(16'h8008, 16);
    settle("b2b");

    expect_frame(16'h0617);
    send_bits(16'h0617, 16);
    settle("f0617");

    // Restore 1024 so the bad-CRC step shows the hold/update difference.
    expect_frame(16'h8008);
    send_bits(16'h8008, 16);
    expect_frame(16'h8009);
    send_bits(16'h8009, 16);
    settle("badcrc");

    expect_error();
    send_bits(16'h0617, 8);
    repeat (60) @(negedge clock);
    settle("low_timeout");
    expect_frame(16'h0617);
    send_bits(16'h0617, 16);
    settle("after_timeout");

    expect_error();
    rxIn = 1'b1;
    repeat (2) @(negedge clock);
    rxIn = 1'b0;
    settle("glitch");

    expect_error();
    rxIn = 1'b1;
    repeat (40) @(negedge clock);
    rxIn = 1'b0;
    settle("stuck_high");

    expect_frame(16'h8008);
    send_bits(16'h8008, 16);
    settle("pre_reset");
    send_bits(16'h0617, 10);
    resetN = 1'b0;
    @(negedge clock);
    resetN     = 1'b1;
    model_cmd  = '0;
    model_tele = 1'b0;
    settle("mid_reset");
    expect_frame(16'h0617);
    send_bits(16'h0617, 16);
    settle("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
